// File: rtl/pic_exec_unit.sv
// rtl/pic_exec_unit.sv - PIC10F200-class execute stage (W, STATUS, file regs, skip); LITERAL_OPS_EN adds literal ops
// Three-state IDLE/EXEC/WB sequencer; one instruction retired every three cycles.
module pic_exec_unit #(
    parameter int DATA_W     = 8,
    parameter int FILE_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       opcode,
    output logic              done,
    output logic              skip,
    output logic              illegal,
    output logic [DATA_W-1:0] w_reg,
    output logic [2:0]        status,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int H = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t            state;
    logic [11:0]       op_q;
    logic [DATA_W-1:0] file_mem [FILE_DEPTH];
    logic [DATA_W-1:0] res_c, res_q, fv;
    logic [2:0]        stat_c, stat_q;
    logic              wr_w_c, wr_f_c, skip_c, ill_c, z_en;
    logic              wr_w_q, wr_f_q, skip_q, ill_q;
    logic [5:0]        op6;
    logic              d;
    logic [4:0]        fld;
    logic              f_ok;
    logic [DATA_W:0]   add_full, sub_full;
    logic [H:0]        add_lo, sub_lo;

    assign op6      = op_q[11:6];
    assign d        = op_q[5];
    assign fld      = op_q[4:0];
    assign f_ok     = ({27'd0, fld} < FILE_DEPTH);
    assign fv       = f_ok ? file_mem[fld] : '0;
    assign dbg_data = ({27'd0, dbg_addr} < FILE_DEPTH) ? file_mem[dbg_addr] : '0;

    // SUB carry bits are inverted borrows: 1 means f >= W
    assign add_full = {1'b0, fv} + {1'b0, w_reg};
    assign sub_full = {1'b0, fv} - {1'b0, w_reg};
    assign add_lo   = {1'b0, fv[H-1:0]} + {1'b0, w_reg[H-1:0]};
    assign sub_lo   = {1'b0, fv[H-1:0]} - {1'b0, w_reg[H-1:0]};

`ifdef LITERAL_OPS_EN
    logic [DATA_W-1:0] k;
    assign k = DATA_W'(op_q[7:0]);
`endif

    always_comb begin
        res_c  = '0;
        stat_c = status;
        wr_w_c = 1'b0;
        wr_f_c = 1'b0;
        skip_c = 1'b0;
        ill_c  = 1'b0;
        z_en   = 1'b0;
        casez (op6)
            6'b000000: begin
                if (d) begin
                    res_c  = w_reg;
                    wr_f_c = 1'b1;
                end else if (fld != 5'd0) begin
                    ill_c = 1'b1;
                end
            end
            6'b000001: begin
                if (d || fld == 5'd0) begin
                    z_en   = 1'b1;
                    wr_f_c = d;
                    wr_w_c = !d;
                end else begin
                    ill_c = 1'b1;
                end
            end
            6'b000010: begin
                res_c     = sub_full[DATA_W-1:0];
                stat_c[0] = ~sub_full[DATA_W];
                stat_c[1] = ~sub_lo[H];
                z_en      = 1'b1;
            end
            6'b000011: begin res_c = fv - DATA_W'(1); z_en = 1'b1; end
            6'b000100: begin res_c = fv | w_reg;      z_en = 1'b1; end
            6'b000101: begin res_c = fv & w_reg;      z_en = 1'b1; end
            6'b000110: begin res_c = fv ^ w_reg;      z_en = 1'b1; end
            6'b000111: begin
                res_c     = add_full[DATA_W-1:0];
                stat_c[0] = add_full[DATA_W];
                stat_c[1] = add_lo[H];
                z_en      = 1'b1;
            end
            6'b001000: begin res_c = fv;              z_en = 1'b1; end
            6'b001001: begin res_c = ~fv;             z_en = 1'b1; end
            6'b001010: begin res_c = fv + DATA_W'(1); z_en = 1'b1; end
            6'b001011: begin
                res_c  = fv - DATA_W'(1);
                skip_c = (res_c == '0);
            end
            6'b001100: begin
                res_c     = {status[0], fv[DATA_W-1:1]};
                stat_c[0] = fv[0];
            end
            6'b001101: begin
                res_c     = {fv[DATA_W-2:0], status[0]};
                stat_c[0] = fv[DATA_W-1];
            end
            6'b001110: res_c = {fv[H-1:0], fv[DATA_W-1:H]};
            6'b001111: begin
                res_c  = fv + DATA_W'(1);
                skip_c = (res_c == '0);
            end
`ifdef LITERAL_OPS_EN
            6'b1100??: begin res_c = k;         wr_w_c = 1'b1; end
            6'b1101??: begin res_c = k | w_reg; wr_w_c = 1'b1; z_en = 1'b1; end
            6'b1110??: begin res_c = k & w_reg; wr_w_c = 1'b1; z_en = 1'b1; end
            6'b1111??: begin res_c = k ^ w_reg; wr_w_c = 1'b1; z_en = 1'b1; end
`endif
            default: ill_c = 1'b1;
        endcase
        // byte-oriented ops 0x02..0x0F steer the result by the d bit
        if (op6[5:4] == 2'b00 && op6[3:1] != 3'b000) begin
            wr_f_c = d;
            wr_w_c = !d;
        end
        if (z_en)
            stat_c[2] = (res_c == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            done     <= 1'b0;
            skip     <= 1'b0;
            illegal  <= 1'b0;
            w_reg    <= '0;
            status   <= '0;
            op_q     <= '0;
            res_q    <= '0;
            stat_q   <= '0;
            wr_w_q   <= 1'b0;
            wr_f_q   <= 1'b0;
            skip_q   <= 1'b0;
            ill_q    <= 1'b0;
            for (int i = 0; i < FILE_DEPTH; i++)
                file_mem[i] <= '0;
        end else begin
            done    <= 1'b0;
            skip    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        op_q     <= opcode;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_q  <= res_c;
                    stat_q <= stat_c;
                    wr_w_q <= wr_w_c;
                    wr_f_q <= wr_f_c;
                    skip_q <= skip_c;
                    ill_q  <= ill_c;
                    state  <= WB;
                end
                WB: begin
                    if (wr_w_q)
                        w_reg <= res_q;
                    if (wr_f_q && f_ok)
                        file_mem[fld] <= res_q;
                    status   <= stat_q;
                    done     <= 1'b1;
                    skip     <= skip_q;
                    illegal  <= ill_q;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
